// File: rtl/wb_sdram_pkg.sv
// Shared definitions for the wb_sdram_model slave.
//   state_e : controller states (S_IDLE=0, S_BUSY=1, S_ACK=2, S_REF=3)
//   clog2   : ceiling log2 for sizing address/counter fields
package wb_sdram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2,
    S_REF  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_sdram_refresh_timer.sv
// Refresh request generator for wb_sdram_model.
// A free-running counter raises a request every PERIOD cycles; the request
// is held in a single pending flag until the controller takes it. A request
// arriving while one is already pending is absorbed.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   take_i    : controller is servicing the pending request this cycle
//   pending_o : a refresh request is waiting
module wb_sdram_refresh_timer
  import wb_sdram_pkg::*;
#(
  parameter int unsigned PERIOD = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic take_i,
  output logic pending_o
);

  localparam int unsigned PW = clog2(PERIOD + 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          req;

  always_comb begin
    req       = (cnt_q == PW'(PERIOD - 1));
    cnt_d     = req ? '0 : cnt_q + PW'(1);
    // A new request re-arms the flag even if the old one is taken now.
    pending_d = req | (pending_q & ~take_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/wb_sdram_model.sv
// Wishbone-classic slave modelling an SDRAM for ConvNet simulation benches.
// Address, data, we and sel are latched at acceptance; each transfer returns
// a single-cycle ack LATENCY cycles after acceptance. Dropping cyc_i before
// the ack aborts the transfer with no write. Memory is not reset.
// Optional refresh stalls are enabled by defining WB_SDRAM_REFRESH_EN.
//   CLK       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cyc_i     : bus cycle valid
//   stb_i     : transfer strobe
//   we_i      : 1 = write, 0 = read
//   sel_i     : byte-lane enables for writes
//   addr_i    : word address (low log2(DEPTH) bits used)
//   data_i    : write data
//   data_o    : read data, valid only with sdram_ack, else 0
//   stall_o   : slave cannot accept a transfer
//   sdram_ack : one-cycle transfer-complete pulse
module wb_sdram_model
  import wb_sdram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                stall_o,
  output logic                sdram_ack
);

  localparam int unsigned AW      = clog2(DEPTH);
  localparam int unsigned SEL_W   = DATA_W / 8;
  localparam int unsigned CNT_MAX = (LATENCY > REFRESH_CYCLES) ? LATENCY : REFRESH_CYCLES;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [SEL_W-1:0]   sel_q;
  logic               we_q;

  logic               ack_q, ack_d;
  logic               stall_q, stall_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               accept;
  logic               abort;
  logic               ref_take;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [SEL_W-1:0]   wr_sel;
  logic [DATA_W-1:0]  wr_mask;

  logic               unused_addr;
  assign unused_addr = ^addr_i;

`ifdef WB_SDRAM_REFRESH_EN
  logic ref_pending;

  wb_sdram_refresh_timer #(
    .PERIOD(REFRESH_PERIOD)
  ) u_refresh (
    .clk_i    (CLK),
    .rst_ni   (rst_n),
    .take_i   (ref_take),
    .pending_o(ref_pending)
  );

  // Refresh wins over a simultaneous request from idle.
  assign ref_take = (state_q == S_IDLE) && ref_pending;
`else
  logic unused_refresh;
  assign ref_take       = 1'b0;
  assign unused_refresh = (REFRESH_PERIOD == 0);
`endif

  assign accept = (state_q == S_IDLE) && !ref_take && cyc_i && stb_i;
  assign abort  = (state_q == S_BUSY) && !cyc_i;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The state enters S_ACK one cycle before the bus sees
  // the ack, because ack/data/stall are registered from the state; this keeps
  // LATENCY=1 (accept straight into S_ACK) and the LATENCY+1 turnaround.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ref_take) begin
          state_d = S_REF;
          cnt_d   = CNT_W'(REFRESH_CYCLES - 1);
        end else if (accept) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? S_BUSY : S_ACK;
        end
      end
      S_BUSY: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_REF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    ack_d   = (state_q == S_ACK);
    stall_d = (state_q != S_IDLE) && !abort;
    rdata_d = '0;
    if (state_q == S_ACK && !we_q) rdata_d = mem_q[addr_q];
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      stall_q <= stall_d;
      rdata_q <= rdata_d;
    end
  end

  assign sdram_ack = ack_q;
  assign stall_o   = stall_q;
  assign data_o    = rdata_q;

  // Request capture
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_i[AW-1:0];
      wdata_q <= data_i;
      sel_q   <= sel_i;
      we_q    <= we_i;
    end
  end

  // Write commit on the edge entering S_ACK; with LATENCY=1 that is the
  // accept edge itself, so the live bus values are used.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_data = wdata_q;
    wr_sel  = sel_q;
    wr_mask = '0;
    if (state_q == S_IDLE) begin
      wr_addr = addr_i[AW-1:0];
      wr_data = data_i;
      wr_sel  = sel_i;
      wr_en   = accept && we_i && (LATENCY == 1);
    end else if (state_q == S_BUSY) begin
      wr_en = cyc_i && we_q && (cnt_q == CNT_W'(1));
    end
    // The memory array has no reset; block commits while reset is held.
    wr_en = wr_en && rst_n;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_sel[b]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

endmodule

// File: doc/wb_sdram_model.md
# wb_sdram_model

Parametrised Wishbone-classic slave that models an SDRAM for simulation benches of the ConvNet datapath. It sits on the `stb_i`/`we_i`/`sel_i`/`cyc_i`/`addr_i`/`data_i` bus driven by `convnet` and returns `data_o`/`stall_o`/`sdram_ack`. Compared with the earlier fixed 120-word, 4-cycle model, it adds:
- configurable depth, data width and access latency;
- byte-lane writes via `sel_i`;
- address and data latched at acceptance;
- single-cycle ack, so multiple transfers can run per `cyc_i` assertion;
- abort on `cyc_i` drop;
- optional refresh stalls.

## Interface
Parameters:
- `DATA_W`, 32: data bus width; multiple of 8.
- `ADDR_W`, 32: `addr_i` width.
- `DEPTH`, 128: number of words; power of two, ≥2.
- `LATENCY`, 4: cycles from accept edge to ack edge; ≥1.
- `REFRESH_PERIOD`, 64: cycles between refresh requests; used only with refresh enabled.
- `REFRESH_CYCLES`, 4: length of the refresh stall; ≥1.

Ports:
- `CLK` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cyc_i` input 1: bus cycle valid.
- `stb_i` input 1: transfer strobe.
- `we_i` input 1: 1 = write, 0 = read.
- `sel_i` input DATA_W/8: byte-lane enables for writes.
- `addr_i` input ADDR_W: word address; low log2(DEPTH) bits are used.
- `data_i` input DATA_W: write data.
- `data_o` output DATA_W: read data; valid only while `sdram_ack`=1, otherwise 0.
- `stall_o` output 1: slave cannot accept a transfer.
- `sdram_ack` output 1: one-cycle transfer-complete pulse.

## Operation
State machine (`S_IDLE`, `S_BUSY`, `S_ACK`, `S_REF`):
- **S_IDLE**:
  - `stall_o`=0.
  - If `cyc_i`&`stb_i` at an edge: latch `addr_i[log2(DEPTH)-1:0]`, `data_i`, `we_i` and `sel_i`; load the latency counter with LATENCY-1. Go to `S_BUSY` if LATENCY>1, else `S_ACK`.
- **S_BUSY**:
  - `stall_o`=1; the counter decrements each edge.
  - When the counter reaches 0, go to `S_ACK`.
  - `cyc_i`=0 at any edge: go to `S_IDLE`, no ack, no write.
- **S_ACK**:
  - `sdram_ack`=1 for exactly one cycle and `stall_o`=1.
  - Write: `mem[addr] <= (mem & ~mask) | (data & mask)`, with the mask built from the latched `sel`. Commit happens on the edge that enters `S_ACK`.
  - Read: `data_o` = `mem[addr]`.
  - Always returns to `S_IDLE` the next edge; `cyc_i` dropping during `S_ACK` does not cancel it.
- Address wraps modulo DEPTH; upper address bits are ignored.
- Inputs are sampled only at accept; changes to `addr_i`/`data_i` afterwards have no effect.
- Reset:
  - Asynchronous; forces `S_IDLE`, `sdram_ack`=0, `stall_o`=0, `data_o`=0, counters=0.
  - A transfer in flight is dropped (no write commit).
  - Memory contents are unaffected by reset.

## Timing
- Accept at edge E0 → `sdram_ack` high from edge E0+LATENCY to E0+LATENCY+1.
- Maximum throughput is one transfer per LATENCY+1 cycles; the next accept is possible at edge E0+LATENCY+1.
- `stall_o` is registered from the state: high from E0+1 (`S_BUSY`/`S_ACK`) until the edge returning to `S_IDLE`.
- With LATENCY=1, ack is high in the cycle right after accept.
- `data_o` is registered; it is 0 outside ack cycles.

## Configuration
- Macro `WB_SDRAM_REFRESH_EN`.
- **Defined**:
  - A free-running counter raises a refresh request every REFRESH_PERIOD cycles.
  - The request is serviced only from `S_IDLE`, with priority over a simultaneous `cyc_i`&`stb_i`.
  - `S_REF` holds `stall_o`=1 for REFRESH_CYCLES cycles, then returns to `S_IDLE`.
  - A request arriving during `S_BUSY`/`S_ACK` stays pending; only one is pending at a time, and extra requests are dropped.
- **Undefined**: no refresh logic; `S_REF` is unreachable; `stall_o` is high only in `S_BUSY`/`S_ACK`.

## Structure
- Shared package `wb_sdram_pkg`: state encoding constants (`S_IDLE`=0, `S_BUSY`=1, `S_ACK`=2, `S_REF`=3) and a clog2 helper function.
- One sub-module, `wb_sdram_refresh_timer`: period counter and pending flag with a `take` input. It is instantiated only under `WB_SDRAM_REFRESH_EN`.

## Test plan
- **Write/read, LATENCY=4**: write 0xDEADBEEF to addr 5 with sel=0xF. Ack at accept+4. Read addr 5 → `data_o`=0xDEADBEEF with ack at accept+4, and `data_o`=0 the cycle after.
- **Byte lanes**: mem[7]=0x11223344; write 0xAABBCCDD with sel=0x5. A read returns 0x11BB33DD.
- **Wrap/back-to-back**: DEPTH=128; write 0x1 to addr 0x80 and read addr 0 within one `cyc_i`. The read returns 0x1. Second accept occurs exactly LATENCY+1 cycles after the first.
- **Abort**: drop `cyc_i` two cycles after accepting a write of 0xFFFFFFFF to addr 3. No ack; addr 3 keeps its prior value; `stall_o`=0 next cycle.
- **Reset mid-transfer**: assert `rst_n`=0 during `S_BUSY`. All outputs go to 0 immediately, with no write. After release, the next transfer acks normally.
- **Refresh** (`WB_SDRAM_REFRESH_EN`, PERIOD=16, CYCLES=4): hold `cyc_i`&`stb_i` high continuously. Exactly 4 stall cycles are inserted at each period expiry; no transfer is lost or duplicated.
